// File: rtl/vtg_pkg.sv
// vtg_pkg: shared phase type, SVGA defaults and total helpers for the video timing generator.
// VTG_FRAME_CNT_EN (optional) adds the frame counter in vid_timing_gen.
package vtg_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    FPORCH,
    SYNC,
    BPORCH
  } vtg_phase_e;

  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;

  function automatic int vtg_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

  function automatic vtg_phase_e vtg_phase_succ(
    input vtg_phase_e p
  );
    unique case (p)
      ACTIVE:  return FPORCH;
      FPORCH:  return SYNC;
      SYNC:    return BPORCH;
      default: return ACTIVE;
    endcase
  endfunction

endpackage

// File: rtl/vtg_axis_cnt.sv
// vtg_axis_cnt: one timing axis -- position counter plus ACTIVE/FPORCH/SYNC/BPORCH phase FSM.
// cnt/phase present the value the axis will hold after the current edge.
module vtg_axis_cnt
  import vtg_pkg::*;
#(
  parameter int ACT_LEN  = SVGA_H_ACTIVE,
  parameter int FP_LEN   = SVGA_H_FP,
  parameter int SYNC_LEN = SVGA_H_SYNC,
  parameter int BP_LEN   = SVGA_H_BP,
  parameter int CNT_W    = 12
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             advance,
  input  logic             park,
  output logic             wrap,
  output logic [CNT_W-1:0] cnt,
  output vtg_phase_e       phase
);

  localparam int TOTAL =
    vtg_total(ACT_LEN, FP_LEN, SYNC_LEN, BP_LEN);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] BP_LAST =
    CNT_W'(BP_LEN - 1);

  if (ACT_LEN < 1 || FP_LEN < 1 ||
      SYNC_LEN < 1 || BP_LEN < 1) begin : g_bad_len
    $error("vtg_axis_cnt: zero-length phase");
  end

  if (TOTAL > 2**CNT_W) begin : g_bad_width
    $error("vtg_axis_cnt: total exceeds 2**CNT_W");
  end

  logic [CNT_W-1:0] pos_q;
  logic [CNT_W-1:0] ph_cnt_q;
  logic [CNT_W-1:0] ph_cnt_d;
  logic [CNT_W-1:0] ph_last;
  vtg_phase_e       phase_q;

  // Last in-phase count of the phase currently held.
  always_comb begin
    ph_last = BP_LAST;
    unique case (phase_q)
      ACTIVE: ph_last = CNT_W'(ACT_LEN - 1);
      FPORCH: ph_last = CNT_W'(FP_LEN - 1);
      SYNC:   ph_last = CNT_W'(SYNC_LEN - 1);
      BPORCH: ph_last = BP_LAST;
    endcase
  end

  assign wrap = advance & (pos_q == LAST);

  // Next position/phase: park wins, otherwise step on advance.
  always_comb begin
    cnt      = pos_q;
    ph_cnt_d = ph_cnt_q;
    phase    = phase_q;
    if (park) begin
      cnt      = LAST;
      ph_cnt_d = BP_LAST;
      phase    = BPORCH;
    end else if (advance) begin
      cnt = wrap ? '0 : pos_q + CNT_W'(1);
      if (ph_cnt_q == ph_last) begin
        ph_cnt_d = '0;
        phase    = vtg_phase_succ(phase_q);
      end else begin
        ph_cnt_d = ph_cnt_q + CNT_W'(1);
      end
    end
  end

  // State register; reset parks at the last back-porch position.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pos_q    <= LAST;
      ph_cnt_q <= BP_LAST;
      phase_q  <= BPORCH;
    end else begin
      pos_q    <= cnt;
      ph_cnt_q <= ph_cnt_d;
      phase_q  <= phase;
    end
  end

endmodule

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: registered SVGA-style sync/blank/sof generator driven by an advance enable.
// Define VTG_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vid_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE  = SVGA_H_ACTIVE,
  parameter int H_FP      = SVGA_H_FP,
  parameter int H_SYNC    = SVGA_H_SYNC,
  parameter int H_BP      = SVGA_H_BP,
  parameter int V_ACTIVE  = SVGA_V_ACTIVE,
  parameter int V_FP      = SVGA_V_FP,
  parameter int V_SYNC    = SVGA_V_SYNC,
  parameter int V_BP      = SVGA_V_BP,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CNT_W     = 12
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        gen_en,
  input  logic        clken,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank,
  output logic        active_video,
  output logic        sof
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  logic             advance;
  logic             park;
  logic             h_wrap;
  logic             v_wrap_unused;
  logic             sof_d;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  vtg_phase_e       h_ph;
  vtg_phase_e       v_ph;

  assign advance = gen_en & clken;
  assign park    = ~gen_en;

  vtg_axis_cnt #(
    .ACT_LEN  (H_ACTIVE),
    .FP_LEN   (H_FP),
    .SYNC_LEN (H_SYNC),
    .BP_LEN   (H_BP),
    .CNT_W    (CNT_W)
  ) u_h (
    .aclk    (aclk),
    .aresetn (aresetn),
    .advance (advance),
    .park    (park),
    .wrap    (h_wrap),
    .cnt     (h_cnt),
    .phase   (h_ph)
  );

  vtg_axis_cnt #(
    .ACT_LEN  (V_ACTIVE),
    .FP_LEN   (V_FP),
    .SYNC_LEN (V_SYNC),
    .BP_LEN   (V_BP),
    .CNT_W    (CNT_W)
  ) u_v (
    .aclk    (aclk),
    .aresetn (aresetn),
    .advance (advance & h_wrap),
    .park    (park),
    .wrap    (v_wrap_unused),
    .cnt     (v_cnt),
    .phase   (v_ph)
  );

  assign sof_d = (h_cnt == '0) & (v_cnt == '0);

  // Outputs decoded from the next position so they line up with the counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hsync        <= ~HSYNC_POL;
      vsync        <= ~VSYNC_POL;
      hblank       <= 1'b1;
      vblank       <= 1'b1;
      active_video <= 1'b0;
      sof          <= 1'b0;
    end else if (!gen_en) begin
      hsync        <= ~HSYNC_POL;
      vsync        <= ~VSYNC_POL;
      hblank       <= 1'b1;
      vblank       <= 1'b1;
      active_video <= 1'b0;
      sof          <= 1'b0;
    end else if (clken) begin
      hsync        <= (h_ph == SYNC) ? HSYNC_POL
                                     : ~HSYNC_POL;
      vsync        <= (v_ph == SYNC) ? VSYNC_POL
                                     : ~VSYNC_POL;
      hblank       <= (h_ph != ACTIVE);
      vblank       <= (v_ph != ACTIVE);
      active_video <= (h_ph == ACTIVE) &
                      (v_ph == ACTIVE);
      sof          <= sof_d;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  // Frames started since gen_en rose; bumps with each sof.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt <= '0;
    end else if (!gen_en) begin
      frame_cnt <= '0;
    end else if (clken && sof_d) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vid_timing_gen.sv
// tb_vid_timing_gen: directed checks of vid_timing_gen on a reduced 15x8 raster.
// Expected outputs come from an arithmetic raster model indexed by advance count.
module tb_vid_timing_gen;

  localparam int HA = 8;
  localparam int HFP = 2;
  localparam int HS = 3;
  localparam int HBP = 2;
  localparam int VA = 4;
  localparam int VFP = 1;
  localparam int VS = 2;
  localparam int VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [5:0] IDLE = 6'b001100;

  logic aclk = 1'b0;
  logic aresetn;
  logic gen_en;
  logic clken;
  logic hsync, vsync, hblank, vblank;
  logic active_video, sof;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif
  logic [5:0] obs;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int cyc = 0;

  assign obs = {hsync, vsync, hblank, vblank,
                active_video, sof};

  vid_timing_gen #(
    .H_ACTIVE  (HA),
    .H_FP      (HFP),
    .H_SYNC    (HS),
    .H_BP      (HBP),
    .V_ACTIVE  (VA),
    .V_FP      (VFP),
    .V_SYNC    (VS),
    .V_BP      (VBP),
    .HSYNC_POL (1'b1),
    .VSYNC_POL (1'b1),
    .CNT_W     (5)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .gen_en       (gen_en),
    .clken        (clken),
    .hsync        (hsync),
    .vsync        (vsync),
    .hblank       (hblank),
    .vblank       (vblank),
    .active_video (active_video),
    .sof          (sof)
`ifdef VTG_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  // Expected {hsync,vsync,hblank,vblank,active,sof} after kk advances.
  function automatic logic [5:0] exp_vec(input int kk);
    int p, h, v;
    logic hb, vb, hs, vs;
    if (kk == 0) return IDLE;
    p  = (kk - 1) % FRAME;
    h  = p % HT;
    v  = p / HT;
    hb = (h >= HA);
    vb = (v >= VA);
    hs = (h >= HA + HFP) && (h < HA + HFP + HS);
    vs = (v >= VA + VFP) && (v < VA + VFP + VS);
    return {hs, vs, hb, vb, !hb && !vb, p == 0};
  endfunction

  task automatic tick();
    logic run, adv;
    run = aresetn & gen_en;
    adv = clken;
    @(posedge aclk);
    #1;
    cyc++;
    if (!run) k = 0;
    else if (adv) k++;
  endtask

  task automatic restart();
    gen_en = 1'b0;
    clken = 1'b1;
    tick();
    gen_en = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    gen_en = 1'b0;
    clken = 1'b0;
    #50;
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", obs, IDLE);
    end
`ifdef VTG_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame_cnt got=%0d exp=0",
               frame_cnt);
    end
`endif
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    clken = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs !== IDLE) begin
        errors++;
        $display("FAIL parked cyc=%0d got=%b exp=%b",
                 cyc, obs, IDLE);
      end
    end
  endtask

  task automatic test_free_run();
    logic [5:0] e;
    logic prev;
    int last;
    prev = 1'b0;
    last = -1;
    restart();
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      tick();
      e = exp_vec(k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL free_run k=%0d got=%b exp=%b",
                 k, obs, e);
      end
      if (sof === 1'b1 && !prev) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != FRAME) begin
            errors++;
            $display("FAIL sof_period got=%0d exp=%0d",
                     cyc - last, FRAME);
          end
        end
        last = cyc;
      end
      prev = sof;
    end
  endtask

  task automatic test_clken_half();
    logic [5:0] e;
    logic prev;
    int last;
    prev = 1'b0;
    last = -1;
    restart();
    for (int i = 0; i < 4 * FRAME + 20; i++) begin
      clken = (i % 2 == 0);
      tick();
      e = exp_vec(k);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL half_rate k=%0d got=%b exp=%b",
                 k, obs, e);
      end
      if (sof === 1'b1 && !prev) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != 2 * FRAME) begin
            errors++;
            $display("FAIL half_period got=%0d exp=%0d",
                     cyc - last, 2 * FRAME);
          end
        end
        last = cyc;
      end
      prev = sof;
    end
    clken = 1'b1;
  endtask

  task automatic test_gen_drop();
    logic [5:0] e;
    restart();
    for (int i = 0; i < 3 * HT + 5 + 1; i++) tick();
    e = exp_vec(k);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL drop_pre k=%0d got=%b exp=%b",
               k, obs, e);
    end
    gen_en = 1'b0;
    clken = 1'b0;
    tick();
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL drop_blank got=%b exp=%b",
               obs, IDLE);
    end
    gen_en = 1'b1;
    clken = 1'b1;
    tick();
    checks++;
    if (obs !== 6'b000011) begin
      errors++;
      $display("FAIL reraise_sof got=%b exp=%b",
               obs, 6'b000011);
    end
    clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 6'b000011) begin
        errors++;
        $display("FAIL clken_hold i=%0d got=%b exp=%b",
                 i, obs, 6'b000011);
      end
    end
    clken = 1'b1;
    tick();
    e = exp_vec(k);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL resume k=%0d got=%b exp=%b",
               k, obs, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] e;
    restart();
    for (int i = 0; i < 40; i++) tick();
    #3;
    aresetn = 1'b0;
    #1;
    k = 0;
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL async_reset got=%b exp=%b",
               obs, IDLE);
    end
    tick();
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL reset_held got=%b exp=%b",
               obs, IDLE);
    end
    aresetn = 1'b1;
    tick();
    e = exp_vec(k);
    checks++;
    if (obs !== 6'b000011 || obs !== e) begin
      errors++;
      $display("FAIL post_reset_sof got=%b exp=%b",
               obs, 6'b000011);
    end
  endtask

`ifdef VTG_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int n;
    n = 0;
    restart();
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (sof === 1'b1) begin
        n++;
        checks++;
        if (frame_cnt !== 16'(n)) begin
          errors++;
          $display("FAIL frame_cnt got=%0d exp=%0d",
                   frame_cnt, n);
        end
      end
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL sof_count got=%0d exp=3", n);
    end
    gen_en = 1'b0;
    tick();
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL frame_cnt_clear got=%0d exp=0",
               frame_cnt);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_run();
    test_clken_half();
    test_gen_drop();
    test_reset_mid();
`ifdef VTG_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
